// File: rtl/evt_time_compressor_pkg.sv
// evt_time_compressor_pkg: event stream types shared by the time compressor and its stream interface.
package evt_time_compressor_pkg;

    localparam int TIME_W = 16;
    localparam int PAYLOAD_W = 16;

    typedef enum logic [1:0] {
        EVT_SPIKE  = 2'd0,
        EVT_TIME   = 2'd1,
        EVT_SYNC   = 2'd2,
        EVT_UPDATE = 2'd3
    } evt_op_t;

    typedef logic [TIME_W-1:0] time_t;

    typedef struct packed {
        evt_op_t operation;
        time_t   value;
    } timestamp_t;

    typedef struct packed {
        timestamp_t             timestamp;
        logic [PAYLOAD_W-1:0]   payload;
    } evt_t;

endpackage

// File: rtl/evt_time_compressor_if.sv
// SNE_EVENT_STREAM: valid/ready event stream with source and destination views.
interface SNE_EVENT_STREAM;
    import evt_time_compressor_pkg::*;

    evt_t evt;
    logic valid;
    logic ready;

    modport src (output evt, output valid, input ready);
    modport dst (input evt, input valid, output ready);

endinterface

// File: rtl/evt_time_compressor.sv
// evt_time_compressor: drops time events of empty timesteps, holding the latest time
// until a data event, keep-alive limit, flush or disable forces it downstream.
module evt_time_compressor
    import evt_time_compressor_pkg::*;
#(
    parameter int MAX_GAP = 0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                enable_i,
    input  logic                flush_i,
    SNE_EVENT_STREAM.dst        evt_stream_dst,
    SNE_EVENT_STREAM.src        evt_stream_src,
    output logic                time_drop_o
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PENDING = 2'd1;
    localparam logic [1:0] EMIT    = 2'd2;

    localparam int GW = (MAX_GAP < 2) ? 1 : $clog2(MAX_GAP + 1);
    localparam logic [GW:0] GAP_LIM = MAX_GAP[GW:0];

    logic [1:0]    state_q, state_d;
    time_t         held_q, held_d;
    time_t         last_q, last_d;
    logic          last_vld_q, last_vld_d;
    logic [GW-1:0] gap_q, gap_d;

    logic          is_time, incr, keep_alive;
    time_t         in_t;
    logic [GW-1:0] gap_base;
    logic [GW:0]   gap_inc;

    assign is_time    = evt_stream_dst.evt.timestamp.operation == EVT_TIME;
    assign in_t       = evt_stream_dst.evt.timestamp.value;
    assign incr       = (state_q == PENDING) ? (in_t > held_q) : (!last_vld_q || in_t > last_q);
    // gap counts absorbed steps of the current held run, including the one that opened it
    assign gap_base   = (state_q == IDLE) ? '0 : gap_q;
    assign gap_inc    = {1'b0, gap_base} + {{GW{1'b0}}, 1'b1};
    assign keep_alive = (MAX_GAP != 0) && (gap_inc == GAP_LIM);

    always_comb begin
        evt_stream_src.evt   = evt_stream_dst.evt;
        evt_stream_src.valid = evt_stream_dst.valid;
        evt_stream_dst.ready = evt_stream_src.ready;
        time_drop_o          = 1'b0;
        state_d              = state_q;
        held_d               = held_q;
        last_d               = last_q;
        last_vld_d           = last_vld_q;
        gap_d                = gap_q;
        if (state_q == EMIT) begin
            evt_stream_src.evt   = '{timestamp: '{operation: EVT_TIME, value: held_q}, payload: '0};
            evt_stream_src.valid = 1'b1;
            evt_stream_dst.ready = 1'b0;
            if (evt_stream_src.ready) begin
                last_d     = held_q;
                last_vld_d = 1'b1;
                state_d    = IDLE;
            end
        end else if (state_q == IDLE && !enable_i) begin
            if (evt_stream_dst.valid && evt_stream_src.ready && is_time) begin
                last_d     = in_t;
                last_vld_d = 1'b1;
            end
        end else if (state_q == PENDING && (flush_i || !enable_i || (evt_stream_dst.valid && !is_time))) begin
            evt_stream_src.valid = 1'b0;
            evt_stream_dst.ready = 1'b0;
            state_d              = EMIT;
        end else if (is_time) begin
            evt_stream_src.valid = 1'b0;
            evt_stream_dst.ready = 1'b1;
            if (evt_stream_dst.valid && incr) begin
                held_d  = in_t;
                gap_d   = gap_inc[GW-1:0];
                state_d = keep_alive ? EMIT : PENDING;
            end else begin
                time_drop_o = evt_stream_dst.valid;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            held_q     <= '0;
            last_q     <= '0;
            last_vld_q <= 1'b0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            held_q     <= held_d;
            last_q     <= last_d;
            last_vld_q <= last_vld_d;
            gap_q      <= gap_d;
        end
    end

endmodule
